// File: rtl/word_boundary_detector_pkg.sv
// Shared types for the word boundary detector: FSM encoding, index type and word payload.
package word_boundary_detector_pkg;

    localparam int unsigned IDX_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ONSET    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_HANGOVER = 2'd3
    } state_e;

    typedef struct packed {
        idx_t start_idx;
        idx_t end_idx;
    } word_t;

endpackage

// File: rtl/word_boundary_detector_word_out_reg.sv
// Holds the pending word until acknowledged; flags words lost while the slot is occupied.
module word_out_reg
    import word_boundary_detector_pkg::*;
(
    input  logic  iclk,
    input  logic  irstn,
    input  logic  emit_i,
    input  word_t word_i,
    input  logic  ack_i,
    output logic  valid_o,
    output word_t word_o,
    output logic  ovf_o
);

    logic  valid_q, valid_d;
    word_t word_q,  word_d;
    logic  ovf_q,   ovf_d;

    // An ack in the same cycle frees the slot, so the new word replaces the held one
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        if (emit_i) begin
            if (!valid_q || ack_i) begin
                valid_d = 1'b1;
                word_d  = word_i;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ack_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/word_boundary_detector.sv
// Hysteresis word detector on a smoothed level stream; emits inclusive sample-index bounds
// of each word that survives onset confirmation, hangover and minimum-length filtering.
module word_boundary_detector
    import word_boundary_detector_pkg::*;
#(
    parameter logic [15:0] THRESH_ON  = 16'd100,
    parameter logic [15:0] THRESH_OFF = 16'd60,
    parameter int unsigned MIN_ON     = 3,
    parameter int unsigned HANGOVER   = 4,
    parameter int unsigned MIN_LEN    = 8
) (
    input  logic        iclk,
    input  logic        irstn,
    input  logic        ivalid,
    input  logic [15:0] idata,
    input  logic [31:0] iidx,
    input  logic        iflush,
    input  logic        iack,
    output logic        oword_valid,
    output logic [31:0] ostart_idx,
    output logic [31:0] oend_idx,
    output logic        obusy,
    output logic        oovf
);

    state_e state_q, state_d;
    cnt_t   on_cnt_q, on_cnt_d;
    cnt_t   off_cnt_q, off_cnt_d;
    idx_t   cand_start_q, cand_start_d;
    idx_t   last_hi_q, last_hi_d;
    logic   busy_q;

    logic   hi_on_c, hi_off_c, close_c, emit_c;
    idx_t   len_c;
    word_t  word_c, word_out_c;

    assign hi_on_c  = idata >= THRESH_ON;
    assign hi_off_c = idata >= THRESH_OFF;

    // Closing samples are always below THRESH_OFF, so the registered last_hi is the word end
    assign len_c  = last_hi_q - cand_start_q + idx_t'(1);
    assign emit_c = close_c && (len_c >= idx_t'(MIN_LEN));
    assign word_c = '{start_idx: cand_start_q, end_idx: last_hi_q};

    always_comb begin
        state_d      = state_q;
        on_cnt_d     = on_cnt_q;
        off_cnt_d    = off_cnt_q;
        cand_start_d = cand_start_q;
        last_hi_d    = last_hi_q;
        close_c      = 1'b0;

        if (iflush) begin
            close_c = (state_q == ST_ACTIVE) || (state_q == ST_HANGOVER);
            state_d = ST_IDLE;
        end else if (ivalid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hi_on_c) begin
                        cand_start_d = iidx;
                        on_cnt_d     = cnt_t'(1);
                        state_d      = (MIN_ON == 1) ? ST_ACTIVE : ST_ONSET;
                    end
                end
                ST_ONSET: begin
                    if (hi_on_c) begin
                        on_cnt_d = on_cnt_q + cnt_t'(1);
                        if (on_cnt_d == cnt_t'(MIN_ON)) begin
                            state_d = ST_ACTIVE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (hi_off_c) begin
                        last_hi_d = iidx;
                    end else begin
                        off_cnt_d = cnt_t'(1);
                        if (HANGOVER == 1) begin
                            close_c = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HANGOVER;
                        end
                    end
                end
                ST_HANGOVER: begin
                    if (hi_off_c) begin
                        last_hi_d = iidx;
                        off_cnt_d = '0;
                        state_d   = ST_ACTIVE;
                    end else begin
                        off_cnt_d = off_cnt_q + cnt_t'(1);
                        if (off_cnt_d == cnt_t'(HANGOVER)) begin
                            close_c = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iclk) begin
        if (!irstn) begin
            state_q      <= ST_IDLE;
            on_cnt_q     <= '0;
            off_cnt_q    <= '0;
            cand_start_q <= '0;
            last_hi_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            on_cnt_q     <= on_cnt_d;
            off_cnt_q    <= off_cnt_d;
            cand_start_q <= cand_start_d;
            last_hi_q    <= last_hi_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    word_out_reg u_word_out_reg (
        .iclk    (iclk),
        .irstn   (irstn),
        .emit_i  (emit_c),
        .word_i  (word_c),
        .ack_i   (iack),
        .valid_o (oword_valid),
        .word_o  (word_out_c),
        .ovf_o   (oovf)
    );

    assign ostart_idx = word_out_c.start_idx;
    assign oend_idx   = word_out_c.end_idx;
    assign obusy      = busy_q;

endmodule

// File: tb/tb_word_boundary_detector.sv
// Scoreboard bench for word_boundary_detector: directed scenarios plus randomized level streams.
module tb_word_boundary_detector;

    localparam logic [15:0] T_ON    = 16'd100;
    localparam logic [15:0] T_OFF   = 16'd60;
    localparam int          MIN_ON  = 3;
    localparam int          HANG    = 4;
    localparam int          MIN_LEN = 8;

    logic        iclk = 1'b0;
    logic        irstn, ivalid, iflush, iack;
    logic [15:0] idata;
    logic [31:0] iidx;
    logic        oword_valid, obusy, oovf;
    logic [31:0] ostart_idx, oend_idx;

    always #5 iclk = ~iclk;

    word_boundary_detector #(
        .THRESH_ON  (T_ON),
        .THRESH_OFF (T_OFF),
        .MIN_ON     (MIN_ON),
        .HANGOVER   (HANG),
        .MIN_LEN    (MIN_LEN)
    ) dut (
        .iclk        (iclk),
        .irstn       (irstn),
        .ivalid      (ivalid),
        .idata       (idata),
        .iidx        (iidx),
        .iflush      (iflush),
        .iack        (iack),
        .oword_valid (oword_valid),
        .ostart_idx  (ostart_idx),
        .oend_idx    (oend_idx),
        .obusy       (obusy),
        .oovf        (oovf)
    );

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        x;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          words_seen = 0;
    bit          chk_en = 0;

    // Reference model state, named after the behaviour it describes
    int          m_state;   // 0 idle, 1 confirming onset, 2 in word, 3 closing
    int          m_on, m_off;
    logic [31:0] m_cand, m_last;
    bit          slot, e_ovf, e_busy;
    logic [31:0] idx_ctr;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_on = 0; m_off = 0;
        m_cand = '0; m_last = '0;
        slot = 0; e_ovf = 0; e_busy = 0;
    endtask

    // Apply one cycle of inputs, predict its effect, then advance past the clock edge
    task automatic drive(input bit v, input logic [15:0] d, input bit fl, input bit ak);
        bit          close, nxt_ovf;
        logic [31:0] len;
        exp_t        w;
        ivalid = v; idata = d; iidx = idx_ctr; iflush = fl; iack = ak;
        close = 0;
        nxt_ovf = e_ovf;
        if (fl) begin
            close = (m_state >= 2);
            m_state = 0;
        end else if (v) begin
            case (m_state)
                0: if (d >= T_ON) begin
                       m_cand = idx_ctr; m_on = 1;
                       m_state = (MIN_ON == 1) ? 2 : 1;
                   end
                1: if (d >= T_ON) begin
                       m_on++;
                       if (m_on == MIN_ON) m_state = 2;
                   end else m_state = 0;
                2: if (d >= T_OFF) m_last = idx_ctr;
                   else begin
                       m_off = 1;
                       if (HANG == 1) close = 1; else m_state = 3;
                   end
                default: if (d >= T_OFF) begin
                       m_last = idx_ctr; m_off = 0; m_state = 2;
                   end else begin
                       m_off++;
                       if (m_off == HANG) close = 1;
                   end
            endcase
        end
        if (close) m_state = 0;
        len = m_last - m_cand + 32'd1;
        if (close && len >= 32'(MIN_LEN)) begin
            if (!slot || ak) begin
                w.s = m_cand; w.e = m_last; w.cyc = cyc + 1;
                q.push_back(w);
                slot = 1;
            end else begin
                nxt_ovf = 1;
            end
        end else if (ak) begin
            slot = 0;
        end
        if (v && !fl) idx_ctr++;
        @(posedge iclk);
        e_ovf  = nxt_ovf;
        e_busy = (m_state != 0);
        #1;
    endtask

    task automatic run(input int n, input logic [15:0] d, input bit ak);
        repeat (n) drive(1'b1, d, 1'b0, ak);
    endtask

    task automatic do_reset();
        irstn = 0; ivalid = 0; iflush = 0; iack = 0;
        @(posedge iclk); #1;
        chk("rst_word_valid", 64'(oword_valid), 64'd0);
        chk("rst_start_idx", 64'(ostart_idx), 64'd0);
        chk("rst_end_idx", 64'(oend_idx), 64'd0);
        chk("rst_busy", 64'(obusy), 64'd0);
        chk("rst_ovf", 64'(oovf), 64'd0);
        model_reset();
        q.delete();
        irstn = 1;
    endtask

    // Monitor: pops an expectation each time a new word is presented
    bit          held = 0;
    logic [31:0] h_s, h_e;
    always @(negedge iclk) begin
        if (chk_en && irstn) begin
            chk("obusy", 64'(obusy), 64'(e_busy));
            chk("oovf", 64'(oovf), 64'(e_ovf));
            if (!oword_valid) begin
                held = 0;
            end else if (!held) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(ostart_idx), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    x = q.pop_front();
                    chk("word_start", 64'(ostart_idx), 64'(x.s));
                    chk("word_end", 64'(oend_idx), 64'(x.e));
                    chk("word_cycle", 64'(cyc), 64'(x.cyc));
                    words_seen++;
                end
                held = 1; h_s = ostart_idx; h_e = oend_idx;
            end else begin
                chk("hold_start", 64'(ostart_idx), 64'(h_s));
                chk("hold_end", 64'(oend_idx), 64'(h_e));
            end
            if (oword_valid && iack) held = 0;
        end
    end

    initial begin
        irstn = 0; ivalid = 0; idata = '0; iidx = '0; iflush = 0; iack = 0;
        idx_ctr = '0;
        model_reset();
        repeat (3) @(posedge iclk);
        #1;
        chk("init_word_valid", 64'(oword_valid), 64'd0);
        chk("init_start_idx", 64'(ostart_idx), 64'd0);
        chk("init_end_idx", 64'(oend_idx), 64'd0);
        chk("init_busy", 64'(obusy), 64'd0);
        chk("init_ovf", 64'(oovf), 64'd0);
        irstn = 1;
        chk_en = 1;

        // Basic word 5..14
        idx_ctr = 0; run(5, 16'd0, 1); run(10, 16'd120, 1); run(6, 16'd0, 1);
        // Onset too short
        idx_ctr = 0; run(2, 16'd120, 1); run(10, 16'd0, 1);
        // Gap shorter than hangover bridges two bursts
        idx_ctr = 0; run(6, 16'd120, 1); run(3, 16'd0, 1); run(6, 16'd120, 1); run(6, 16'd0, 1);
        // Too short, then exactly MIN_LEN, then one short of it
        idx_ctr = 0; run(4, 16'd120, 1); run(6, 16'd0, 1);
        run(8, 16'd120, 1); run(6, 16'd0, 1);
        run(7, 16'd120, 1); run(6, 16'd0, 1);
        // Threshold edge values: 100 opens, 60 sustains, 59 closes
        run(3, 16'd100, 1); run(6, 16'd60, 1); run(4, 16'd59, 1); run(2, 16'd0, 1);
        // Overflow: second word dropped while first held
        idx_ctr = 0; run(10, 16'd120, 0); run(6, 16'd0, 0); run(10, 16'd120, 0); run(6, 16'd0, 0);
        chk("ovf_sticky", 64'(oovf), 64'd1);
        chk("ovf_held_start", 64'(ostart_idx), 64'd0);
        run(3, 16'd0, 1);
        // Flush closes with current last_hi; reset discards open word
        idx_ctr = 0; run(9, 16'd120, 1); drive(1'b1, 16'd120, 1'b1, 1'b1); run(3, 16'd0, 1);
        idx_ctr = 0; run(9, 16'd120, 1); do_reset(); run(6, 16'd0, 1);

        // Randomized level streams, second pass straddling index wraparound
        for (int pass = 0; pass < 2; pass++) begin
            idx_ctr = (pass == 0) ? 32'd0 : 32'hFFFF_FFC0;
            for (int s = 0; s < 200; s++) begin
                int          cls, len;
                logic [15:0] d;
                cls = int'($urandom_range(0, 2));
                len = int'($urandom_range(1, 12));
                for (int k = 0; k < len; k++) begin
                    case (cls)
                        0:       d = ($urandom % 4 == 0) ? 16'd59 : 16'($urandom_range(0, 59));
                        1:       d = ($urandom % 2 == 0) ? 16'd60 : 16'd99;
                        default: d = ($urandom % 4 == 0) ? 16'd100 : 16'($urandom_range(100, 65535));
                    endcase
                    drive(($urandom % 5) != 0, d, ($urandom % 40) == 0, ($urandom % 3) == 0);
                end
            end
            run(12, 16'd0, 1);
        end
        do_reset();
        run(4, 16'd0, 1);

        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("words_seen_min", 64'(words_seen > 10), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_boundary_detector.md
WORD_BOUNDARY_DETECTOR -- requirements
Module: word_boundary_detector

Interface
REQ-001 The block SHALL have parameter THRESH_ON, default 16'd100: smoothed level that opens a word.
REQ-002 The block SHALL have parameter THRESH_OFF, default 16'd60: level below which a word starts closing; THRESH_OFF <= THRESH_ON.
REQ-003 The block SHALL have parameter MIN_ON, default 3: consecutive samples >= THRESH_ON needed to confirm onset; range 1..255.
REQ-004 The block SHALL have parameter HANGOVER, default 4: consecutive samples < THRESH_OFF needed to close a word; range 1..255.
REQ-005 The block SHALL have parameter MIN_LEN, default 8: minimum word length in samples; shorter words are discarded.
REQ-006 The block SHALL have port iclk, input, 1 bit: clock; all logic rising-edge.
REQ-007 The block SHALL have port irstn, input, 1 bit: reset, synchronous, active-low.
REQ-008 The block SHALL have port ivalid, input, 1 bit: idata/iidx valid (the moving-average ovalid).
REQ-009 The block SHALL have port idata, input, 16 bits: smoothed unsigned level.
REQ-010 The block SHALL have port iidx, input, 32 bits: sample index of idata.
REQ-011 The block SHALL have port iflush, input, 1 bit: force-close any open word.
REQ-012 The block SHALL have port iack, input, 1 bit: consumer accepts the pending word.
REQ-013 The block SHALL have ports oword_valid (1 bit), ostart_idx (32 bits) and oend_idx (32 bits), outputs: pending word and its inclusive bounds.
REQ-014 The block SHALL have port obusy, output, 1 bit: FSM not IDLE.
REQ-015 The block SHALL have port oovf, output, 1 bit: sticky flag, a word was dropped.

Function
REQ-016 The FSM SHALL have states IDLE, ONSET, ACTIVE and HANGOVER, and SHALL advance only on cycles with ivalid=1; it SHALL hold otherwise.
REQ-017 In IDLE, idata >= THRESH_ON SHALL latch cand_start=iidx and set on_cnt=1, then enter ONSET, or enter ACTIVE directly when MIN_ON=1.
REQ-018 In ONSET, idata >= THRESH_ON SHALL increment on_cnt and enter ACTIVE when on_cnt reaches MIN_ON; idata < THRESH_ON SHALL return the FSM to IDLE with no word.
REQ-019 In ACTIVE, each idata >= THRESH_OFF SHALL set last_hi=iidx; idata < THRESH_OFF SHALL set off_cnt=1 and enter HANGOVER, or close immediately when HANGOVER=1.
REQ-020 In HANGOVER, idata >= THRESH_OFF SHALL set last_hi=iidx, clear off_cnt and return to ACTIVE; idata < THRESH_OFF SHALL increment off_cnt, and close when off_cnt reaches HANGOVER.
REQ-021 Close SHALL compute len = last_hi - cand_start + 1 modulo 2^32, emit the word (start=cand_start, end=last_hi) if len >= MIN_LEN, and go to IDLE.
REQ-022 An emitted word SHALL register ostart_idx/oend_idx and assert oword_valid on the cycle after the closing sample.
REQ-023 oword_valid SHALL stay high with stable bounds until a cycle with iack=1, and SHALL deassert the following cycle.
REQ-024 A word emitted while oword_valid=1 and iack=0 SHALL be dropped and SHALL set oovf; the held word SHALL remain unchanged.
REQ-025 When an emit and iack occur in the same cycle, the new word SHALL replace the old one, oword_valid SHALL stay 1, and oovf SHALL remain unchanged.
REQ-026 iflush=1 SHALL take priority over ivalid and drop that cycle's sample.
REQ-027 iflush in ACTIVE or HANGOVER SHALL close per REQ-021 using the current last_hi; iflush in ONSET or IDLE SHALL go to IDLE with no word.
REQ-028 on_cnt and off_cnt SHALL be 8-bit; idata comparisons SHALL be unsigned 16-bit.
REQ-029 obusy SHALL be registered state != IDLE.

Reset
REQ-030 irstn=0 at a rising edge SHALL force IDLE; clear on_cnt, off_cnt, cand_start and last_hi; set oword_valid=0, ostart_idx=0, oend_idx=0, oovf=0 and obusy=0.
REQ-031 Reset mid-word SHALL discard the open word without emitting it.

Structure
REQ-032 A shared package SHALL hold the 2-bit state encoding (IDLE=0, ONSET=1, ACTIVE=2, HANGOVER=3) and the 32-bit index typedef.
REQ-033 The FSM and counters SHALL live in this module, with one sub-module word_out_reg holding the output register, iack handshake and oovf logic.

Verification (defaults; samples at consecutive indices from 0, one per cycle)
REQ-034 Stimulus 0x5, 120x10 (idx 5-14), 0x6 SHALL produce start=5 and end=14, with oword_valid high the cycle after idx 18.
REQ-035 Stimulus 120x2 then 0x10 SHALL produce no word, with obusy high for 2 cycles only.
REQ-036 Stimulus 120x6, 0x3, 120x6, 0x4 SHALL produce a single word with start=0 and end=14.
REQ-037 Stimulus 120x4 then 0x4 SHALL produce no word, because len=4 < 8.
REQ-038 Two valid words with iack held 0 SHALL keep the first word held, set oovf=1, and leave the second word unseen.
REQ-039 Stimulus 120x9, then iflush at idx 9 SHALL produce start=0 and end=8; 120x9 followed by irstn=0 SHALL produce no word and all outputs 0.
